// File: rtl/counter_mod_n.sv
// -----------------------------------------------------------------------------
// counter_mod_n
//
// Parametrised modulo-N counter with these features:
//   - an enable that passes through a prescaler
//   - up/down direction
//   - synchronous clear and load
//   - a registered wrap pulse
// A free-running reference count runs beside the gated count.
// o_wrap is meant to cascade into the i_en of the next counter stage.
//
// Parameters
//   MOD_N     modulus, o_cnt spans 0..MOD_N-1 (MOD_N >= 2)
//   CNT_W     count width, 2**CNT_W must be >= MOD_N
//   PRESCALE  enabled cycles per count step (1 = every enabled cycle)
//
// Ports
//   clk           clock, all state on rising edge
//   reset         asynchronous active-high reset, clears every register
//   i_en          count enable, feeds the prescaler
//   i_up          1 = count up, 0 = count down, sampled at each step
//   i_clear       synchronous clear of count and prescaler
//   i_load        synchronous load of i_load_val (clamped to MOD_N-1)
//   i_load_val    load value
//   o_cnt         gated count, registered
//   o_cnt_always  free-running up count 0..MOD_N-1, registered
//   o_wrap        one-cycle pulse, high while o_cnt shows a wrapped value
//
// Build option
//   COUNTER_MOD_N_SAT_EN  when defined, o_cnt saturates at the limits.
//   o_wrap then pulses on the step that reaches a limit.
//   Further steps at the limit give o_wrap = 0.
//   o_cnt_always wraps in both builds.
// -----------------------------------------------------------------------------
module counter_mod_n #(
    parameter int MOD_N    = 100,
    parameter int CNT_W    = 7,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_always,
    output logic             o_wrap
);

    // Reject illegal parameter combinations at elaboration.
    if (MOD_N < 2) begin : g_bad_mod
        $error("counter_mod_n: MOD_N must be >= 2");
    end
    if ((64'(1) << CNT_W) < 64'(MOD_N)) begin : g_bad_width
        $error("counter_mod_n: CNT_W too narrow for MOD_N");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mod_n: PRESCALE must be >= 1");
    end

    localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MOD_N - 1);
`ifdef COUNTER_MOD_N_SAT_EN
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MOD_N - 2);
`endif

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_always_reg, cnt_always_next;
    logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
    logic             wrap_reg, wrap_next;
    logic             step;

    // A step happens on the enabled cycle that completes a prescaler period.
    assign step = i_en && (pre_cnt_reg == PRE_MAX);

    always_comb begin
        cnt_next     = cnt_reg;
        pre_cnt_next = pre_cnt_reg;
        wrap_next    = 1'b0;

        if (i_clear) begin
            cnt_next     = '0;
            pre_cnt_next = '0;
        end else if (i_load) begin
            cnt_next     = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
            pre_cnt_next = '0;
        end else if (step) begin
            pre_cnt_next = '0;
            // Limits are compared before the add/subtract.
            // This keeps the arithmetic in CNT_W bits without overflow.
            if (i_up) begin
`ifdef COUNTER_MOD_N_SAT_EN
                if (cnt_reg != MAX_VAL) begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                    wrap_next = (cnt_reg == MAX_M1);
                end
`else
                if (cnt_reg == MAX_VAL) begin
                    cnt_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                end
`endif
            end else begin
`ifdef COUNTER_MOD_N_SAT_EN
                if (cnt_reg != '0) begin
                    cnt_next  = cnt_reg - CNT_W'(1);
                    wrap_next = (cnt_reg == CNT_W'(1));
                end
`else
                if (cnt_reg == '0) begin
                    cnt_next  = MAX_VAL;
                    wrap_next = 1'b1;
                end else begin
                    cnt_next  = cnt_reg - CNT_W'(1);
                end
`endif
            end
        end else if (i_en) begin
            pre_cnt_next = pre_cnt_reg + PRE_W'(1);
        end
    end

    // The reference count ignores every control input except reset.
    assign cnt_always_next = (cnt_always_reg == MAX_VAL) ? '0
                                                         : cnt_always_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            cnt_always_reg <= '0;
            pre_cnt_reg    <= '0;
            wrap_reg       <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            cnt_always_reg <= cnt_always_next;
            pre_cnt_reg    <= pre_cnt_next;
            wrap_reg       <= wrap_next;
        end
    end

    assign o_cnt        = cnt_reg;
    assign o_cnt_always = cnt_always_reg;
    assign o_wrap       = wrap_reg;

endmodule

// File: tb/tb_counter_mod_n.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_n
//
// Self-checking bench for counter_mod_n.
// It drives a default instance (MOD_N=100, PRESCALE=1) and a PRESCALE=4
// instance from one clock.
// Each cycle, a reference model predicts the next outputs.
// The predictions go to a scoreboard queue and are compared after the edge.
// Directed checks cover the boundary cases:
//   - load clamping
//   - clear-over-load priority
//   - the down-count wrap/saturate sequence
//   - prescaler stall
//   - asynchronous reset between edges
// -----------------------------------------------------------------------------
module tb_counter_mod_n;

    localparam int MOD = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, clr, ld;
    logic [6:0] ld_val;
    logic [6:0] o_cnt, o_cnt_always;
    logic       o_wrap;

    logic       p_en, p_up, p_clr, p_ld;
    logic [6:0] p_ld_val;
    logic [6:0] p_cnt, p_cnt_always;
    logic       p_wrap;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Model state, in the default and prescaled instances.
    int m_cnt = 0, m_pre = 0, m_alw = 0;
    int pm_cnt = 0, pm_pre = 0;

    int wrap_seen;
    int alw_zero_seen;
    int seq_dn[4];
    int seq_wr[4];

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] wrap;
        logic [31:0] alw;
        logic [31:0] pcnt;
        logic [31:0] pwrap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_mod_n dut (
        .clk          (clk),
        .reset        (reset),
        .i_en         (en),
        .i_up         (up),
        .i_clear      (clr),
        .i_load       (ld),
        .i_load_val   (ld_val),
        .o_cnt        (o_cnt),
        .o_cnt_always (o_cnt_always),
        .o_wrap       (o_wrap)
    );

    counter_mod_n #(.MOD_N(100), .CNT_W(7), .PRESCALE(4)) dut_p (
        .clk          (clk),
        .reset        (reset),
        .i_en         (p_en),
        .i_up         (p_up),
        .i_clear      (p_clr),
        .i_load       (p_ld),
        .i_load_val   (p_ld_val),
        .o_cnt        (p_cnt),
        .o_cnt_always (p_cnt_always),
        .o_wrap       (p_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge (not in reset).
    task automatic model(input int mod_n, input int presc, input int cnt, input int pre,
                         input bit m_en, input bit m_up, input bit m_clr, input bit m_ld,
                         input int ldv, output int ncnt, output int npre, output bit nwrap);
        ncnt  = cnt;
        npre  = pre;
        nwrap = 1'b0;
        if (m_clr) begin
            ncnt = 0;
            npre = 0;
        end else if (m_ld) begin
            ncnt = (ldv > mod_n - 1) ? mod_n - 1 : ldv;
            npre = 0;
        end else if (m_en) begin
            if (pre < presc - 1) begin
                npre = pre + 1;
            end else begin
                npre = 0;
                if (m_up) begin
                    if (cnt == mod_n - 1) begin
`ifndef COUNTER_MOD_N_SAT_EN
                        ncnt  = 0;
                        nwrap = 1'b1;
`endif
                    end else begin
                        ncnt = cnt + 1;
`ifdef COUNTER_MOD_N_SAT_EN
                        nwrap = (ncnt == mod_n - 1);
`endif
                    end
                end else begin
                    if (cnt == 0) begin
`ifndef COUNTER_MOD_N_SAT_EN
                        ncnt  = mod_n - 1;
                        nwrap = 1'b1;
`endif
                    end else begin
                        ncnt = cnt - 1;
`ifdef COUNTER_MOD_N_SAT_EN
                        nwrap = (ncnt == 0);
`endif
                    end
                end
            end
        end
    endtask

    // One clock: predict, push, wait for the edge, pop, compare.
    task automatic cycle();
        exp_t e;
        int   nc, np, pc, pp;
        bit   nw, pw;
        model(MOD, 1, m_cnt, m_pre, en, up, clr, ld, int'(ld_val), nc, np, nw);
        model(MOD, 4, pm_cnt, pm_pre, p_en, p_up, p_clr, p_ld, int'(p_ld_val), pc, pp, pw);
        e.cnt   = nc;
        e.wrap  = {31'd0, nw};
        e.alw   = (m_alw == MOD - 1) ? 0 : m_alw + 1;
        e.pcnt  = pc;
        e.pwrap = {31'd0, pw};
        sb.push_back(e);
        m_cnt  = nc;
        m_pre  = np;
        m_alw  = int'(e.alw);
        pm_cnt = pc;
        pm_pre = pp;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        txn++;
        $display("txn %0d cnt=%0d wrap=%0d always=%0d p_cnt=%0d p_wrap=%0d",
                 txn, o_cnt, o_wrap, o_cnt_always, p_cnt, p_wrap);
        chk("cnt", 32'(o_cnt), e.cnt);
        chk("wrap", 32'(o_wrap), e.wrap);
        chk("cnt_always", 32'(o_cnt_always), e.alw);
        chk("p_cnt", 32'(p_cnt), e.pcnt);
        chk("p_wrap", 32'(p_wrap), e.pwrap);
        if (o_wrap === 1'b1) wrap_seen++;
        if (o_cnt_always === 7'd0) alw_zero_seen++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef COUNTER_MOD_N_SAT_EN
        seq_dn = '{1, 0, 0, 0};
        seq_wr = '{0, 1, 0, 0};
`else
        seq_dn = '{1, 0, 99, 98};
        seq_wr = '{0, 0, 1, 0};
`endif
        reset = 1'b1;
        en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = '0;
        p_en = 1'b0; p_up = 1'b1; p_clr = 1'b0; p_ld = 1'b0; p_ld_val = '0;

        // Reset held for 10 clocks.
        repeat (10) @(posedge clk);
        #1;
        chk("reset_cnt", 32'(o_cnt), 0);
        chk("reset_always", 32'(o_cnt_always), 0);
        chk("reset_wrap", 32'(o_wrap), 0);
        chk("reset_p_cnt", 32'(p_cnt), 0);
        reset = 1'b0;

        // Count up through a full period. Expect exactly one wrap pulse.
        en = 1'b1; up = 1'b1;
        wrap_seen = 0;
        repeat (MOD) cycle();
        chk("up_wrap_count", 32'(wrap_seen), 1);
`ifdef COUNTER_MOD_N_SAT_EN
        chk("up_final", 32'(o_cnt), 99);
`else
        chk("up_final", 32'(o_cnt), 0);
`endif

        // Load 37, then hold. The free-running count keeps going and wraps.
        ld = 1'b1; ld_val = 7'd37;
        cycle();
        ld = 1'b0; en = 1'b0;
        alw_zero_seen = 0;
        for (int i = 0; i < MOD; i++) begin
            cycle();
            if (i == 0 || i == MOD - 1) chk("hold_37", 32'(o_cnt), 37);
        end
        chk("always_wrapped", 32'(alw_zero_seen > 0), 1);

        // Count down from 2.
        ld = 1'b1; ld_val = 7'd2;
        cycle();
        ld = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("down_seq", 32'(o_cnt), 32'(seq_dn[i]));
            chk("down_wrap", 32'(o_wrap), 32'(seq_wr[i]));
        end

        // Load clamp, then clear beating load.
        en = 1'b0; up = 1'b1;
        ld = 1'b1; ld_val = 7'd120;
        cycle();
        chk("load_clamp", 32'(o_cnt), 99);
        chk("load_wrap", 32'(o_wrap), 0);
        clr = 1'b1; ld_val = 7'd50;
        cycle();
        chk("clear_over_load", 32'(o_cnt), 0);
        chk("clear_wrap", 32'(o_wrap), 0);
        clr = 1'b0; ld = 1'b0;

        // PRESCALE=4: a step every 4th enabled clock. A 2-clock enable gap delays it.
        p_en = 1'b1;
        repeat (8) cycle();
        chk("p_two_steps", 32'(p_cnt), 2);
        repeat (2) cycle();
        p_en = 1'b0;
        repeat (2) cycle();
        p_en = 1'b1;
        cycle();
        chk("p_delayed", 32'(p_cnt), 2);
        cycle();
        chk("p_step_late", 32'(p_cnt), 3);
        p_en = 1'b0;

        // Async reset asserted between edges while o_cnt is 55.
        ld = 1'b1; ld_val = 7'd55;
        cycle();
        ld = 1'b0;
        cycle();
        chk("pre_reset_cnt", 32'(o_cnt), 55);
        #3 reset = 1'b1;
        #1;
        chk("async_cnt", 32'(o_cnt), 0);
        chk("async_always", 32'(o_cnt_always), 0);
        chk("async_wrap", 32'(o_wrap), 0);
        chk("async_p_cnt", 32'(p_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_wrap", 32'(o_wrap), 0);
        reset = 1'b0;
        m_cnt = 0; m_pre = 0; m_alw = 0; pm_cnt = 0; pm_pre = 0;
        en = 1'b1; up = 1'b1;
        repeat (5) cycle();
        chk("post_reset_cnt", 32'(o_cnt), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
